sram_bist_march_ctrl: RTL and testbench

SRAM_BIST_MARCH_CTRL -- requirements
Module: sram_bist_march_ctrl

---
 rtl/sram_bist_march_ctrl_if.sv | 35 +++
 rtl/sram_bist_march_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_sram_bist_march_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_bist_march_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_bist_march_ctrl_if
// Description : SRAM port bundle between the March C- BIST controller and
//               the array under test.
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_bist_march_ctrl_if #(
   parameter int ADDR_WIDTH  = 11,
   parameter int DATA_WIDTH  = 64,
   parameter int WMASK_WIDTH = 8
);
   logic                   we;
   logic [WMASK_WIDTH-1:0] wmask;
   logic [ADDR_WIDTH-1:0]  addr;
   logic [DATA_WIDTH-1:0]  din;
   logic [DATA_WIDTH-1:0]  dout;

   modport master (
      output we,
      output wmask,
      output addr,
      output din,
      input  dout
   );

   modport slave (
      input  we,
      input  wmask,
      input  addr,
      input  din,
      output dout
   );
endinterface
`default_nettype wire

// File: rtl/sram_bist_march_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sram_bist_march_ctrl
// Description : March C- SRAM BIST controller, one SRAM op per cycle, with
//               sticky fail flag. Optional first-failure capture enabled by
//               macro SRAM_BIST_FAIL_CAPTURE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_bist_march_ctrl #(
   parameter int ADDR_WIDTH  = 11,
   parameter int DATA_WIDTH  = 64,
   parameter int WMASK_WIDTH = 8
) (
   input  wire logic                  clk,
   input  wire logic                  reset,
   input  wire logic                  start,
   input  wire logic [DATA_WIDTH-1:0] bg,
   output logic                       busy,
   output logic                       done,
   output logic                       fail,
   output logic [ADDR_WIDTH-1:0]      fail_addr,
   output logic [2:0]                 fail_elem,
   output logic [DATA_WIDTH-1:0]      fail_data,
   sram_bist_march_ctrl_if.master     sram
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] c_last_addr = '1;
   localparam logic [ADDR_WIDTH-1:0] c_addr_one  = ADDR_WIDTH'(1);

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [2:0]              r_elem;
   logic [2:0]              w_elem_nxt;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [ADDR_WIDTH-1:0]   w_addr_nxt;
   logic                    r_phase;
   logic                    w_phase_nxt;
   logic [DATA_WIDTH-1:0]   r_bg;
   logic                    w_load;

   logic                    w_down;
   logic                    w_two_op;
   logic                    w_is_read;
   logic                    w_elem_end;
   logic                    w_rd_issue;
   logic [DATA_WIDTH-1:0]   w_wr_data;
   logic [DATA_WIDTH-1:0]   w_rd_exp;

   logic                    w_we;
   logic [WMASK_WIDTH-1:0]  w_wmask;
   logic [ADDR_WIDTH-1:0]   w_addr;
   logic [DATA_WIDTH-1:0]   w_din;

   logic                    r_cmp_vld;
   logic [DATA_WIDTH-1:0]   r_cmp_exp;
   logic                    r_fail;
   logic                    w_mismatch;

   // Element decode: M3/M4 walk downward, M1..M4 are read-then-write pairs.
   assign w_down     = (r_elem == 3'd3) || (r_elem == 3'd4);
   assign w_two_op   = (r_elem >= 3'd1) && (r_elem <= 3'd4);
   assign w_is_read  = (r_elem != 3'd0) && !r_phase;
   assign w_elem_end = w_down ? (r_addr == '0) : (r_addr == c_last_addr);
   assign w_wr_data  = ((r_elem == 3'd1) || (r_elem == 3'd3)) ? ~r_bg : r_bg;
   assign w_rd_exp   = ((r_elem == 3'd2) || (r_elem == 3'd4)) ? ~r_bg : r_bg;
   assign w_rd_issue = (r_state == RUN) && w_is_read;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_elem  <= 3'd0;
         r_addr  <= '0;
         r_phase <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_elem  <= w_elem_nxt;
         r_addr  <= w_addr_nxt;
         r_phase <= w_phase_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_elem_nxt  = r_elem;
      w_addr_nxt  = r_addr;
      w_phase_nxt = r_phase;
      w_load      = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      w_we        = 1'b0;
      w_wmask     = '0;
      w_addr      = '0;
      w_din       = '0;
      case (r_state)
         IDLE, DONE: begin
            done = (r_state == DONE);
            if (start) begin
               w_state_nxt = RUN;
               w_load      = 1'b1;
               w_elem_nxt  = 3'd0;
               w_addr_nxt  = '0;
               w_phase_nxt = 1'b0;
            end
         end
         RUN: begin
            busy   = 1'b1;
            w_addr = r_addr;
            if (!w_is_read) begin
               w_we    = 1'b1;
               w_wmask = '1;
               w_din   = w_wr_data;
            end
            if (w_two_op && !r_phase) begin
               w_phase_nxt = 1'b1;
            end else begin
               w_phase_nxt = 1'b0;
               if (w_elem_end) begin
                  // Element boundary: reload the next element's start address.
                  if (r_elem == 3'd5) begin
                     w_state_nxt = DRAIN;
                     w_addr_nxt  = '0;
                  end else begin
                     w_elem_nxt = r_elem + 3'd1;
                     w_addr_nxt = ((r_elem == 3'd2) || (r_elem == 3'd3)) ? c_last_addr : '0;
                  end
               end else begin
                  w_addr_nxt = w_down ? (r_addr - c_addr_one) : (r_addr + c_addr_one);
               end
            end
         end
         DRAIN: begin
            busy        = 1'b1;
            w_state_nxt = DONE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign sram.we    = w_we;
   assign sram.wmask = w_wmask;
   assign sram.addr  = w_addr;
   assign sram.din   = w_din;

   // Read data returns one cycle after issue; compare against the value
   // registered alongside the read.
   assign w_mismatch = r_cmp_vld && (sram.dout != r_cmp_exp);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cmp_vld <= 1'b0;
         r_cmp_exp <= '0;
         r_fail    <= 1'b0;
         r_bg      <= '0;
      end else begin
         r_cmp_vld <= w_rd_issue;
         if (w_rd_issue) begin
            r_cmp_exp <= w_rd_exp;
         end
         if (w_load) begin
            r_fail <= 1'b0;
            r_bg   <= bg;
         end else if (w_mismatch) begin
            r_fail <= 1'b1;
         end
      end
   end

   assign fail = r_fail;

`ifdef SRAM_BIST_FAIL_CAPTURE_EN
   logic [2:0]            r_cmp_elem;
   logic [ADDR_WIDTH-1:0] r_cmp_addr;
   logic [ADDR_WIDTH-1:0] r_fail_addr;
   logic [2:0]            r_fail_elem;
   logic [DATA_WIDTH-1:0] r_fail_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cmp_elem  <= 3'd0;
         r_cmp_addr  <= '0;
         r_fail_addr <= '0;
         r_fail_elem <= 3'd0;
         r_fail_data <= '0;
      end else begin
         if (w_rd_issue) begin
            r_cmp_elem <= r_elem;
            r_cmp_addr <= r_addr;
         end
         if (w_load) begin
            r_fail_addr <= '0;
            r_fail_elem <= 3'd0;
            r_fail_data <= '0;
         end else if (w_mismatch && !r_fail) begin
            // Only the first mismatch since start is kept.
            r_fail_addr <= r_cmp_addr;
            r_fail_elem <= r_cmp_elem;
            r_fail_data <= sram.dout;
         end
      end
   end

   assign fail_addr = r_fail_addr;
   assign fail_elem = r_fail_elem;
   assign fail_data = r_fail_data;
`else
   assign fail_addr = '0;
   assign fail_elem = 3'd0;
   assign fail_data = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_bist_march_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_bist_march_ctrl
// Description : Scoreboard bench for the March C- BIST controller on a
//               16-word SRAM model with injectable stuck-at faults.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_bist_march_ctrl;

   localparam int AW = 4;
   localparam int DW = 64;
   localparam int MW = 8;
   localparam int N  = 16;
   localparam int c_busy_cycles = 10 * N + 1;
   localparam int c_run_writes  = 5 * N;
`ifdef SRAM_BIST_FAIL_CAPTURE_EN
   localparam bit c_cap = 1'b1;
`else
   localparam bit c_cap = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [DW-1:0] bg = '0;
   logic          busy;
   logic          done;
   logic          fail;
   logic [AW-1:0] fail_addr;
   logic [2:0]    fail_elem;
   logic [DW-1:0] fail_data;

   always #5 clk = ~clk;

   sram_bist_march_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(MW)) sram_if ();

   sram_bist_march_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WMASK_WIDTH(MW)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .bg        (bg),
      .busy      (busy),
      .done      (done),
      .fail      (fail),
      .fail_addr (fail_addr),
      .fail_elem (fail_elem),
      .fail_data (fail_data),
      .sram      (sram_if)
   );

   // SRAM model with one-cycle registered read and stuck-at cells.
   logic [DW-1:0] mem [N];
   logic          sa1_en = 1'b0;
   logic          sa0_en = 1'b0;
   logic [AW-1:0] sa1_addr = '0;
   logic [AW-1:0] sa0_addr = '0;
   logic [DW-1:0] sa1_mask = '0;
   logic [DW-1:0] sa0_mask = '0;
   int            wr_cnt = 0;

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                           input logic [MW-1:0] m);
      logic [DW-1:0] w;
      w = old;
      for (int b = 0; b < MW; b++) if (m[b]) w[b*8 +: 8] = d[b*8 +: 8];
      return w;
   endfunction

   function automatic logic [DW-1:0] faulty(input logic [AW-1:0] a, input logic [DW-1:0] v);
      logic [DW-1:0] r;
      r = v;
      if (sa1_en && a == sa1_addr) r = r | sa1_mask;
      if (sa0_en && a == sa0_addr) r = r & ~sa0_mask;
      return r;
   endfunction

   always @(posedge clk) begin
      if (sram_if.we === 1'b1) begin
         mem[sram_if.addr] <= merge(mem[sram_if.addr], sram_if.din, sram_if.wmask);
         wr_cnt            <= wr_cnt + 1;
      end
      sram_if.dout <= faulty(sram_if.addr, mem[sram_if.addr]);
   end

   // Scoreboard queues
   typedef struct packed {
      logic          we;
      logic [MW-1:0] wmask;
      logic [AW-1:0] addr;
      logic [DW-1:0] din;
   } op_t;

   typedef struct {
      string        name;
      logic [182:0] v;
   } snap_t;

   op_t   op_q[$];
   snap_t snap_q[$];
   int    n_pass = 0;
   int    n_chk  = 0;

   function automatic logic [182:0] pack_obs(input logic b, input logic d, input logic f,
                                             input logic we, input logic [7:0] wm,
                                             input logic [3:0] a, input logic [63:0] di,
                                             input logic [3:0] fa, input logic [2:0] fe,
                                             input logic [63:0] fd, input int wc);
      logic [31:0] w32;
      w32 = wc;
      return {b, d, f, we, wm, a, di, fa, fe, fd, w32};
   endfunction

   // Monitor: consumes expected ops while busy, run totals at done, snapshots on request.
   initial begin : monitor
      int   busy_cnt;
      logic busy_q;
      logic done_q;
      op_t  got;
      op_t  exp;
      snap_t s;
      logic [182:0] act;
      busy_cnt = 0;
      busy_q   = 1'b0;
      done_q   = 1'b0;
      forever begin
         @(negedge clk);
         if (busy) begin
            busy_cnt = busy_q ? busy_cnt + 1 : 1;
            got = {sram_if.we, sram_if.wmask, sram_if.addr, sram_if.din};
            n_chk++;
            if (op_q.size() == 0) begin
               $display("FAIL op_trace: got we/wmask/addr/din=%h, required no op (queue empty)", got);
            end else begin
               exp = op_q.pop_front();
               if (got === exp) n_pass++;
               else $display("FAIL op_trace: got we/wmask/addr/din=%h required %h", got, exp);
            end
         end
         if (reset) op_q.delete();
         if (done && !done_q) begin
            n_chk++;
            if (busy_cnt == c_busy_cycles) n_pass++;
            else $display("FAIL busy_cycles: got %0d required %0d", busy_cnt, c_busy_cycles);
            n_chk++;
            if (op_q.size() == 0) n_pass++;
            else $display("FAIL op_leftover: got %0d unissued ops required 0", op_q.size());
         end
         if (snap_q.size() > 0) begin
            s   = snap_q.pop_front();
            act = pack_obs(busy, done, fail, sram_if.we, sram_if.wmask, sram_if.addr, sram_if.din,
                           fail_addr, fail_elem, fail_data, wr_cnt);
            n_chk++;
            if (act === s.v) n_pass++;
            else $display("FAIL %s: got %h required %h", s.name, act, s.v);
         end
         busy_q = busy;
         done_q = done;
      end
   end

   // Stimulus
   task automatic push_trace(input logic [DW-1:0] pbg);
      for (int e = 0; e < 6; e++) begin
         for (int i = 0; i < N; i++) begin
            logic [AW-1:0] a;
            a = (e == 3 || e == 4) ? AW'(N - 1 - i) : AW'(i);
            if (e != 0) op_q.push_back({1'b0, 8'h00, a, 64'h0});
            if (e != 5) op_q.push_back({1'b1, 8'hFF, a, (e == 1 || e == 3) ? ~pbg : pbg});
         end
      end
      op_q.push_back('0);
   endtask

   task automatic pulse_start();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic expect_snap(input string nm, input logic b, input logic d, input logic f,
                              input logic we, input logic [7:0] wm, input logic [3:0] a,
                              input logic [63:0] di, input logic [3:0] fa, input logic [2:0] fe,
                              input logic [63:0] fd, input int wc);
      snap_t s;
      s.name = nm;
      s.v    = pack_obs(b, d, f, we, wm, a, di, fa, fe, fd, wc);
      snap_q.push_back(s);
   endtask

   task automatic run_and_check(input string nm, input logic [DW-1:0] pbg, input int glitch_at,
                                input logic ef, input logic [AW-1:0] ea, input logic [2:0] ee,
                                input logic [DW-1:0] ed);
      int mark;
      int n;
      mark = wr_cnt;
      n    = 0;
      bg   = pbg;
      push_trace(pbg);
      pulse_start();
      // First op (M0 write to address 0) is on the bus right after start is sampled.
      expect_snap({nm, "_first_op"}, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 4'd0, pbg,
                  4'd0, 3'd0, 64'd0, mark);
      if (glitch_at > 0) begin
         repeat (glitch_at) @(posedge clk);
         bg = ~pbg;
         pulse_start();
      end
      while (!done && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      expect_snap({nm, "_done"}, 1'b0, 1'b1, ef, 1'b0, 8'h00, 4'd0, 64'd0,
                  c_cap ? ea : 4'd0, c_cap ? ee : 3'd0, c_cap ? ed : 64'd0, mark + c_run_writes);
      @(posedge clk);
      #1;
   endtask

   initial begin : stimulus
      int mark;
      repeat (3) @(posedge clk);
      #1;
      expect_snap("reset_state", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 64'd0, 4'd0, 3'd0, 64'd0, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      run_and_check("clean_bg0", 64'd0, 0, 1'b0, 4'd0, 3'd0, 64'd0);

      sa1_en = 1'b1; sa1_addr = 4'd5; sa1_mask = 64'h1;
      run_and_check("sa1_a5_b0", 64'd0, 0, 1'b1, 4'd5, 3'd1, 64'h1);
      sa1_en = 1'b0;

      sa0_en = 1'b1; sa0_addr = 4'd15; sa0_mask = 64'h8000_0000_0000_0000;
      run_and_check("sa0_a15_b63_bgA", 64'hAAAA_AAAA_AAAA_AAAA, 0, 1'b1, 4'd15, 3'd1,
                    64'h2AAA_AAAA_AAAA_AAAA);
      run_and_check("sa0_a15_b63_bg5", 64'h5555_5555_5555_5555, 0, 1'b1, 4'd15, 3'd2,
                    64'h2AAA_AAAA_AAAA_AAAA);
      sa0_en = 1'b0;

      sa1_en = 1'b1; sa1_addr = 4'd5; sa1_mask = 64'h1;
      run_and_check("start_in_run", 64'h0123_4567_89AB_CDEF, 20, 1'b1, 4'd5, 3'd2,
                    64'hFEDC_BA98_7654_3211);
      sa1_en = 1'b0;
      run_and_check("restart_in_done", 64'd0, 0, 1'b0, 4'd0, 3'd0, 64'd0);

      // Abort mid-test with reset, then confirm the bus stays quiet.
      bg = 64'd0;
      push_trace(64'd0);
      pulse_start();
      repeat (40) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      mark = wr_cnt;
      expect_snap("abort_now", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 64'd0, 4'd0, 3'd0, 64'd0, mark);
      repeat (20) begin
         @(posedge clk);
         #1;
      end
      expect_snap("abort_quiet", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 64'd0, 4'd0, 3'd0, 64'd0, mark);
      @(posedge clk);
      #1;

      run_and_check("restart_after_abort", 64'hFFFF_0000_FFFF_0000, 0, 1'b0, 4'd0, 3'd0, 64'd0);

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
